edge_event_sched: RTL

EDGE_EVENT_SCHED -- requirements
Module: edge_event_sched

---
 rtl/edge_event_sched_if.sv | 9 +
 rtl/edge_event_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/edge_event_sched_if.sv
// Event offer handshake between the edge scheduler (master) and its consumer (slave).
interface edge_event_sched_if;
    logic       evt_val;
    logic       evt_rdy;
    logic [2:0] evt_idx;

    modport master (output evt_val, output evt_idx, input evt_rdy);
    modport slave  (input evt_val, input evt_idx, output evt_rdy);
endinterface

// File: rtl/edge_event_sched.sv
// Eight-channel rising-edge detector with sticky pending/overflow flags and a
// round-robin single-event offer port.
module edge_event_sched (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 in_,
    input  logic [7:0]                 en,
    input  logic                       clr_ovf,
    edge_event_sched_if.master         evt,
    output logic [7:0]                 pending,
    output logic [7:0]                 overflow
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [7:0] prev_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] overflow_q, overflow_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] evt_idx_q, evt_idx_d;
    logic       evt_val_q, evt_val_d;
    logic [7:0] edge_s;
    logic [7:0] acc_vec_s;
    logic       accept_s;
    logic [3:0] pick_s;

    // Returns {found, index} of the first set request at start, start+1, ... mod 8.
    function automatic logic [3:0] first_from(input logic [7:0] req, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] pos;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            pos = start + 3'(k);
            if (req[pos]) begin
                res = {1'b1, pos};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign edge_s   = ~prev_q & in_ & en;
    assign accept_s = evt_val_q & evt.evt_rdy;
    assign pick_s   = first_from(pending_q, ptr_q);

    // Pending and overflow flag update; a new edge always beats a same-cycle clear.
    always_comb begin
        acc_vec_s = 8'h00;
        if (accept_s) begin
            acc_vec_s[evt_idx_q] = 1'b1;
        end else begin
            acc_vec_s = 8'h00;
        end
        pending_d  = edge_s | (pending_q & ~acc_vec_s);
        overflow_d = (edge_s & pending_q & ~acc_vec_s) | (overflow_q & {8{~clr_ovf}});
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 8'h00) begin
                    state_d = OFFER;
                end else begin
                    state_d = IDLE;
                end
            end
            OFFER: begin
                if (accept_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OFFER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the offered index, valid flag and search pointer.
    always_comb begin
        evt_idx_d = evt_idx_q;
        ptr_d     = ptr_q;
        evt_val_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_s[3]) begin
                    evt_idx_d = pick_s[2:0];
                    evt_val_d = 1'b1;
                end else begin
                    evt_val_d = 1'b0;
                end
            end
            OFFER: begin
                if (accept_s) begin
                    ptr_d     = evt_idx_q + 3'd1;
                    evt_val_d = 1'b0;
                end else begin
                    evt_val_d = 1'b1;
                end
            end
            default: begin
                evt_idx_d = 3'd0;
                ptr_d     = 3'd0;
                evt_val_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; prev resets high so inputs already asserted stay silent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= 8'hFF;
            pending_q  <= 8'h00;
            overflow_q <= 8'h00;
            ptr_q      <= 3'd0;
            evt_idx_q  <= 3'd0;
            evt_val_q  <= 1'b0;
        end else begin
            prev_q     <= in_;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            ptr_q      <= ptr_d;
            evt_idx_q  <= evt_idx_d;
            evt_val_q  <= evt_val_d;
        end
    end

    assign evt.evt_val = evt_val_q;
    assign evt.evt_idx = evt_idx_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

endmodule
